// File: rtl/cond_exec_stage.sv
// E-stage control register and conditional-execution unit: registers the decode
// control bundle, holds NZCV, and gates all side effects with the condition result.
module cond_exec_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] CondD,
  input  logic [1:0] FlagWD,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       BranchD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic [1:0] ALUControlD,
  input  logic [3:0] ALUFlags,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic [1:0] ALUControlE,
  output logic [3:0] FlagsE
);

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  logic       valid_q, valid_d;
  logic [3:0] cond_q, cond_d;
  logic [1:0] flagw_q, flagw_d;
  logic       pcs_q, pcs_d;
  logic       regw_q, regw_d;
  logic       memw_q, memw_d;
  logic       branch_q, branch_d;
  logic       memtoreg_q, memtoreg_d;
  logic       alusrc_q, alusrc_d;
  logic [1:0] aluctrl_q, aluctrl_d;
  logic [3:0] flags_q, flags_d;

  logic n_f, z_f, c_f, v_f;
  logic cond_pass;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      COND_EQ: cond_pass = z_f;
      COND_NE: cond_pass = ~z_f;
      COND_CS: cond_pass = c_f;
      COND_CC: cond_pass = ~c_f;
      COND_MI: cond_pass = n_f;
      COND_PL: cond_pass = ~n_f;
      COND_VS: cond_pass = v_f;
      COND_VC: cond_pass = ~v_f;
      COND_HI: cond_pass = c_f & ~z_f;
      COND_LS: cond_pass = ~c_f | z_f;
      COND_GE: cond_pass = (n_f == v_f);
      COND_LT: cond_pass = (n_f != v_f);
      COND_GT: cond_pass = ~z_f & (n_f == v_f);
      COND_LE: cond_pass = z_f | (n_f != v_f);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondExE      = valid_q & cond_pass;
  assign PCSrcE       = pcs_q & CondExE;
  assign RegWriteE    = regw_q & CondExE;
  assign MemWriteE    = memw_q & CondExE;
  assign BranchTakenE = branch_q & CondExE;
  assign MemtoRegE    = memtoreg_q;
  assign ALUSrcE      = alusrc_q;
  assign ALUControlE  = aluctrl_q;
  assign FlagsE       = flags_q;

  always_comb begin
    valid_d    = valid_q;
    cond_d     = cond_q;
    flagw_d    = flagw_q;
    pcs_d      = pcs_q;
    regw_d     = regw_q;
    memw_d     = memw_q;
    branch_d   = branch_q;
    memtoreg_d = memtoreg_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    if (FlushE) begin
      valid_d    = 1'b0;
      cond_d     = 4'b0000;
      flagw_d    = 2'b00;
      pcs_d      = 1'b0;
      regw_d     = 1'b0;
      memw_d     = 1'b0;
      branch_d   = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      aluctrl_d  = 2'b00;
    end else if (!StallE) begin
      valid_d    = 1'b1;
      cond_d     = CondD;
      flagw_d    = FlagWD;
      pcs_d      = PCSD;
      regw_d     = RegWD;
      memw_d     = MemWD;
      branch_d   = BranchD;
      memtoreg_d = MemtoRegD;
      alusrc_d   = ALUSrcD;
      aluctrl_d  = ALUControlD;
    end
  end

  // A squashed or stalled instruction must not commit its flags yet.
  always_comb begin
    flags_d = flags_q;
    if (CondExE && !StallE && !FlushE) begin
      if (flagw_q[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flagw_q[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      cond_q     <= 4'b0000;
      flagw_q    <= 2'b00;
      pcs_q      <= 1'b0;
      regw_q     <= 1'b0;
      memw_q     <= 1'b0;
      branch_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= 2'b00;
      flags_q    <= 4'b0000;
    end else begin
      valid_q    <= valid_d;
      cond_q     <= cond_d;
      flagw_q    <= flagw_d;
      pcs_q      <= pcs_d;
      regw_q     <= regw_d;
      memw_q     <= memw_d;
      branch_q   <= branch_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: reset, flag chaining, partial writes,
// failed conditions, stall/flush behaviour and a full condition/flag sweep.
module tb_cond_exec_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       StallE, FlushE;
  logic [3:0] CondD;
  logic [1:0] FlagWD;
  logic       PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD;
  logic [1:0] ALUControlD;
  logic [3:0] ALUFlags;
  logic       CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE;
  logic [1:0] ALUControlE;
  logic [3:0] FlagsE;

  int n_cmp  = 0;
  int n_fail = 0;

  cond_exec_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD),
    .BranchD(BranchD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .ALUFlags(ALUFlags),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .FlagsE(FlagsE)
  );

  always #5 clk = ~clk;

  // {CondExE,PCSrcE,RegWriteE,MemWriteE,BranchTakenE,MemtoRegE,ALUSrcE,ALUControlE,FlagsE}
  function automatic logic [12:0] outs();
    return {CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE,
            MemtoRegE, ALUSrcE, ALUControlE, FlagsE};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                       input logic rw, input logic mw, input logic br);
    CondD = c; FlagWD = fw; PCSD = pcs; RegWD = rw; MemWD = mw; BranchD = br;
    MemtoRegD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 2'b00;
  endtask

  // Reference condition table written from the architectural mnemonics.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n ~^ v;
      4'hB: return n ^ v;
      4'hC: return !z && (n ~^ v);
      4'hD: return z || (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [3:0] f);
    drive(4'hE, 2'b11, 0, 0, 0, 0);
    step();
    ALUFlags = f;
    drive(4'hF, 2'b00, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    StallE = 1'b0; FlushE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {CondD, FlagWD, PCSD, RegWD, MemWD, BranchD} = 10'($urandom);
      {MemtoRegD, ALUSrcD, ALUControlD, ALUFlags} = 8'($urandom);
      step();
      chk("reset_outs", 16'(outs()), 16'h0);
    end
    drive(4'hE, 2'b00, 0, 1, 0, 0);
    MemtoRegD = 1'b1; ALUSrcD = 1'b1; ALUControlD = 2'b10;
    ALUFlags = 4'h0;
    reset = 1'b0;
    #1;
    chk("post_release_outs", 16'(outs()), 16'h0);
    step();
    // CondEx, RegWrite, MemtoReg, ALUSrc, ALUControl=10, flags 0
    chk("first_load", 16'(outs()), 16'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 4'h0}));

    // Flag chain: AL setter then EQ / NE consumers
    drive(4'hE, 2'b11, 0, 0, 0, 0);
    step();
    ALUFlags = 4'b0100;
    drive(4'h0, 2'b00, 0, 1, 0, 0);
    step();
    chk("chain_flags", 16'(FlagsE), 16'h4);
    chk("chain_eq_regw", 16'({CondExE, RegWriteE}), 16'b11);
    ALUFlags = 4'b1011;
    drive(4'h1, 2'b00, 0, 1, 0, 0);
    step();
    chk("chain_ne_regw", 16'({CondExE, RegWriteE}), 16'b00);
    chk("chain_flags_hold", 16'(FlagsE), 16'h4);

    // Partial flag write
    set_flags(4'hF);
    chk("partial_pre", 16'(FlagsE), 16'hF);
    drive(4'hE, 2'b01, 0, 0, 0, 0);
    step();
    ALUFlags = 4'h0;
    StallE = 1'b1;
    step();
    chk("stall_blocks_flags", 16'(FlagsE), 16'hF);
    StallE = 1'b0;
    drive(4'hF, 2'b00, 0, 0, 0, 0);
    step();
    chk("partial_cv", 16'(FlagsE), 16'hC);

    // Failed condition must not write memory or flags
    set_flags(4'h0);
    drive(4'h0, 2'b11, 0, 0, 1, 0);
    step();
    chk("fail_memw", 16'({CondExE, MemWriteE}), 16'b00);
    ALUFlags = 4'hF;
    drive(4'hF, 2'b00, 0, 0, 0, 0);
    step();
    chk("fail_flags_hold", 16'(FlagsE), 16'h0);

    // Flush squashes the flag write of the instruction in E
    drive(4'hE, 2'b11, 0, 0, 0, 0);
    step();
    ALUFlags = 4'b1010;
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    chk("flush_blocks_flags", 16'(FlagsE), 16'h0);

    // BEQ held through a 3-cycle stall, then stall+flush together
    drive(4'hE, 2'b10, 0, 0, 0, 0);
    step();
    ALUFlags = 4'b0100;
    drive(4'h0, 2'b00, 1, 0, 0, 1);
    step();
    chk("beq_taken", 16'({BranchTakenE, PCSrcE, FlagsE}), 16'({2'b11, 4'h4}));
    StallE = 1'b1;
    ALUFlags = 4'h0;
    drive(4'hF, 2'b11, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_beq", 16'({CondExE, BranchTakenE, PCSrcE, FlagsE}), 16'({3'b111, 4'h4}));
    end
    FlushE = 1'b1;
    step();
    // bubble holds CondE=EQ while Z=1: only ValidE keeps CondExE low
    chk("stall_flush_bubble", 16'(outs()), 16'h4);
    FlushE = 1'b0;
    drive(4'hE, 2'b00, 0, 1, 0, 0);
    step();
    chk("stall_holds_bubble", 16'(outs()), 16'h4);

    // Asynchronous reset in the middle of a stall
    StallE = 1'b0;
    step();
    StallE = 1'b1;
    step();
    chk("pre_reset_regw", 16'(RegWriteE), 16'h1);
    #2 reset = 1'b1;
    #1;
    chk("midstall_reset", 16'(outs()), 16'h0);
    #1 reset = 1'b0;
    StallE = 1'b0;

    // Full condition x flags sweep
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 2'b00, 0, 1, 0, 0);
        ALUFlags = ~4'(f);
        step();
        chk($sformatf("sweep_c%0h_f%0h", c, f), 16'({CondExE, RegWriteE}),
            16'({2{ref_cond(4'(c), 4'(f))}}));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
